regfile_dump_reader: RTL
========================

Name: regfile_dump_reader

Overview:
- Read-side master for the register file's read-address/read-data port.
- On a start pulse it sweeps register addresses in ascending order and samples each combinational read value.
- Each word is streamed out with its index over a valid/ready handshake, toward the debug/UART/LED display path.
- The register file's writer is not touched; the block only drives one read-address port.

Parameters:
- n, 32, data width; must match the register file width.
- SKIP_X0, 0, when 1 the sweep starts at register 1; x0 is never emitted.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  cancel the sweep in progress.
- rd_addr  output  5  read-address to register file port (readreg1/readreg2).
- rd_data  input  n  combinational read data returned for rd_addr.
- out_valid  output  1  out_data/out_index hold a word.
- out_ready  input  1  consumer accepts the word when high with out_valid.
- out_data  output  n  sampled register value.
- out_index  output  5  register number of out_data.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset: state=IDLE, addr=0, rd_addr=0, out_valid=0, out_data=0, out_index=0, busy=0, done=0.
- rst has priority over abort; abort has priority over start and the handshake.
- rd_addr is always the registered address counter; it is never combinational from inputs.
- FSM states: IDLE, FETCH, SEND, DONE.
- IDLE: on start=1, addr<=(SKIP_X0?1:0), go FETCH. start=0 stays IDLE. start in any other state is ignored.
- FETCH: rd_addr=addr. At the posedge: out_data<=rd_data, out_index<=addr, out_valid<=1, go SEND.
- SEND: out_valid=1; out_data/out_index held stable until handshake.
- On out_valid&out_ready: out_valid<=0. If addr==31, go DONE; else addr<=addr+1 and go FETCH.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. addr returns to 0.
- Latency: start high at edge E0 -> out_valid high after E1.
- With out_ready tied high, each word takes 2 cycles.
- Full sweep: 32 words (31 with SKIP_X0). done is asserted in the cycle after the final accepting edge.
- abort=1 at any edge in a non-IDLE state -> IDLE next cycle, out_valid=0, addr=0, no done pulse.
- abort in IDLE has no effect.
- Coherency:
  - Each register is sampled at its own FETCH edge; the sweep is not an atomic snapshot.
  - The register file writes on negedge, so a FETCH sample reflects all writes up to the preceding negedge.
- 5-bit addr never wraps; the terminal test is addr==31.
- Reset mid-sweep: same as the reset state above. A following start begins a fresh sweep from the first index.

Test Plan:
- Reset with register file cleared; write x5=0xDEADBEEF, x31=0x12345678. Pulse start with out_ready=1. Required:
  - 32 beats, out_index 0..31, one beat every 2 cycles.
  - x0 reads 0, index 5 = 0xDEADBEEF, index 31 = 0x12345678.
  - done pulses once, 64 cycles after the start edge; busy=0 the cycle after.
- Backpressure: out_ready low 5 cycles on beat index 3. Required: out_valid stays 1 and out_data/out_index stay stable for 5 cycles; index 4 follows only after acceptance; no beat lost or duplicated.
- SKIP_X0=1: sweep emits indices 1..31 only (31 beats); done after index 31 is accepted.
- abort asserted in SEND at index 10. Required: next cycle out_valid=0, busy=0, done never pulses. A new start re-emits from index 0.
- start pulsed repeatedly mid-sweep: ignored, sequence unchanged.
- rst asserted at index 20 with abort also high: all outputs take reset values next cycle.
- Coherency: write x7=0x0000AAAA on the negedge before the FETCH of index 7. Required: out_data=0x0000AAAA at index 7.

Source files
------------

// File: rtl/regfile_dump_reader_if.sv
// Signal bundle between the register-file dump reader and its surroundings.
// The bundle carries the control pins, the register-file read port and the
// output word stream.
//
// Output stream handshake: a word transfers on a rising clock edge where
// out_valid and out_ready are both high. Once out_valid is raised, it stays
// high and out_data/out_index stay unchanged until that transfer. out_valid
// never depends combinationally on out_ready.
interface regfile_dump_reader_if #(
  parameter int n = 32
);
  logic         start;
  logic         abort;
  logic [4:0]   rd_addr;
  logic [n-1:0] rd_data;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] out_data;
  logic [4:0]   out_index;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  // Reader side: drives the read address and the output stream.
  modport master (
    input  start, abort, rd_data, out_ready,
    output rd_addr, out_valid, out_data, out_index, busy, done, state_dbg
  );

  // Environment side: register file, controller and stream consumer.
  modport slave (
    output start, abort, rd_data, out_ready,
    input  rd_addr, out_valid, out_data, out_index, busy, done, state_dbg
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader. A start pulse begins an ascending sweep of the
// register addresses. Each register's combinational read value is sampled in
// its own FETCH cycle, then offered on the output stream with its index.
// done pulses once after the last word is taken. abort cancels a sweep
// without a done pulse.
module regfile_dump_reader #(
  parameter int n       = 32,
  parameter bit SKIP_X0 = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  regfile_dump_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // First register of a sweep; x0 is skipped when it is known to be constant.
  localparam logic [4:0] FIRST_ADDR = SKIP_X0 ? 5'd1 : 5'd0;
  localparam logic [4:0] LAST_ADDR  = 5'd31;

  state_t       state;
  logic [4:0]   addr;
  logic [n-1:0] data_q;
  logic [4:0]   index_q;
  logic         valid_q;
  logic         busy_q;
  logic         done_q;

  // The read address comes straight from the counter. This keeps the
  // register-file read path free of any input-to-output combinational loop.
  assign bus.rd_addr   = addr;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_index = index_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_dbg = state;

  // Sweep controller: state, address counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr    <= 5'd0;
      data_q  <= '0;
      index_q <= 5'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.abort) begin
      // Cancel outright. In IDLE these values are already in place, so an
      // abort there changes nothing. A start seen in the same cycle loses to it.
      state   <= IDLE;
      addr    <= 5'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            addr   <= FIRST_ADDR;
            busy_q <= 1'b1;
            state  <= FETCH;
          end
        end
        FETCH: begin
          // rd_addr has held addr for this whole cycle, so rd_data is the
          // settled value. It includes any write made on the preceding negedge.
          data_q  <= bus.rd_data;
          index_q <= addr;
          valid_q <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
            if (addr == LAST_ADDR) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              addr  <= addr + 5'd1;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          addr   <= 5'd0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
